dec_sel_seq: RTL and testbench
==============================

// Module: dec_sel_seq
// PURPOSE
//  Parametrised, registered select decoder with strobe timing: turns a binary select plus
//  active-low gate into a glitch-free one-hot strobe with programmable setup/pulse/hold.
//  Generalises the combinational 3-to-8 gated decoder for TOM/JERRY chip-select and
//  register-strobe generation, where selects must be clean registered pulses with a handshake.
// PARAMETERS
//  SEL_W  3   select width
//  OUTS   8   number of one-hot outputs; must satisfy 1 <= OUTS <= 2**SEL_W
//  CNT_W  4   width of setup/pulse/hold cycle counts
// PORTS
//  sys_clk    in   1       single clock, all state on rising edge
//  reset      in   1       synchronous, active-high reset
//  req        in   1       request; sampled only while busy==0
//  sel        in   SEL_W   binary select, latched at acceptance
//  gl         in   1       active-low gate, latched at acceptance (1 = null cycle)
//  setup_cyc  in   CNT_W   cycles before strobe, latched at acceptance
//  pulse_cyc  in   CNT_W   strobe length; 0 is treated as 1
//  hold_cyc   in   CNT_W   cycles after strobe before ack
//  busy       out  1       operation in progress
//  z          out  OUTS    registered one-hot strobe
//  ack        out  1       one-cycle completion pulse
//  err        out  1       valid with ack: latched sel >= OUTS
// BEHAVIOUR
//  Reset: state IDLE; z=0, busy=0, ack=0, err=0; counters and latches cleared.
//  Reset mid-operation aborts immediately; no ack is issued for the aborted operation.
//  States: IDLE, SETUP, PULSE, HOLD, DONE.
//  Accept: req=1 and busy=0 (IDLE or DONE) at edge E0. Latch sel, gl, S=setup_cyc,
//   P=max(pulse_cyc,1), H=hold_cyc. Input changes after E0 have no effect.
//  Transitions:
//   - after E0: SETUP if S>0, else PULSE.
//   - SETUP counts S cycles, then PULSE.
//   - PULSE lasts exactly P cycles, then HOLD if H>0, else DONE.
//   - HOLD lasts H cycles, then DONE.
//   - DONE lasts one cycle, then IDLE, or SETUP/PULSE if a new req is accepted in DONE.
//  Timing: z[sel] high after E0+S through E0+S+P-1 (P cycles); ack high for the single
//   cycle after E0+S+P+H. Min latency req->z = 1 cycle (S=0).
//  Min operation: S=0, P=0, H=0 gives z for 1 cycle, then ack 1 cycle later.
//  busy: 1 in SETUP/PULSE/HOLD, 0 in IDLE/DONE, so a req seen with ack gives back-to-back ops.
//  z: at most one bit high in any cycle; all zero outside PULSE. Registered, never combinational.
//  Null cycle (latched gl=1): full timing runs, z stays 0, ack issued, err=0.
//  Out of range (latched sel >= OUTS, gl=0): timing runs, z stays 0, ack with err=1.
//  err is 0 whenever ack is 0.
//  req while busy=1 is ignored, not queued; the requester holds req until accepted.
//  Counters saturate-free: each loaded value counts down to 1; no wrap possible within CNT_W.
// STRUCTURE
//  Package jag_dec_pkg: state encoding (IDLE..DONE) and a function for the max(P,1) clamp.
//  Sub-module dec_onehot #(SEL_W,OUTS): combinational gated binary-to-one-hot
//   (z_n = en & sel==n; out-of-range gives all zero). Instantiated once on the latched
//   sel/gl; its output is registered into z during PULSE.
//  Top: FSM, single shared CNT_W down-counter reloaded at each phase, operand latches.
// TESTING
//  1 S=2,P=3,H=1,sel=5,gl=0, req at E0 -> z=8'h20 after E2..E4, z=0 after E5, ack+busy=0 after E6.
//  2 S=0,P=0,H=0,sel=0 -> z=8'h01 one cycle after E0, ack the next cycle; new req in ack cycle
//    accepted -> second z one cycle later, no idle gap.
//  3 gl=1,sel=3,S=1,P=2,H=0 -> z stays 0 throughout, ack after E3, err=0.
//  4 OUTS=6, sel=7, gl=0 -> z stays 0, ack with err=1; sel=5 -> z=6'h20, err=0.
//  5 reset asserted during PULSE of sel=2 -> z=0, busy=0 next cycle, no ack ever; next req normal.
//  6 req/sel/timing inputs toggled while busy -> ignored; pulse width and position match
//    latched values; assertion $onehot0(z) every cycle.

Source files
------------

// File: rtl/jag_dec_pkg.sv
// Shared definitions for the registered select decoder.
// Contents:
//   state_t    - FSM state encoding (IDLE, SETUP, PULSE, HOLD, DONE)
//   CNT_W_MAX  - widest count the clamp helper handles
//   clamp_min1 - max(v, 1); a zero pulse length means a one-cycle strobe
package jag_dec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int unsigned CNT_W_MAX = 16;

  function automatic logic [CNT_W_MAX-1:0] clamp_min1(input logic [CNT_W_MAX-1:0] v);
    return (v == '0) ? {{(CNT_W_MAX-1){1'b0}}, 1'b1} : v;
  endfunction

endpackage

// File: rtl/dec_sel_seq_onehot.sv
// Combinational gated binary-to-one-hot decoder.
// Ports:
//   sel_i  binary select
//   en_i   active-high enable (all outputs low when 0)
//   z_o    one-hot result; a select >= OUTS yields all zero
module dec_onehot
  import jag_dec_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int OUTS  = 8
) (
  input  logic [SEL_W-1:0] sel_i,
  input  logic             en_i,
  output logic [OUTS-1:0]  z_o
);

  always_comb begin
    z_o = '0;
    for (int n = 0; n < OUTS; n++) begin
      z_o[n] = en_i && (sel_i == SEL_W'(n));
    end
  end

endmodule

// File: rtl/dec_sel_seq.sv
// Registered select decoder with programmable setup/pulse/hold strobe timing.
// An accepted request latches select, gate and timing, then sequences
// SETUP -> PULSE -> HOLD -> DONE, driving one registered one-hot strobe bit
// during PULSE and a one-cycle ack in DONE.
//
//   state | meaning
//   IDLE  | waiting for req
//   SETUP | counting setup cycles, strobe low
//   PULSE | strobe high for the latched select
//   HOLD  | counting hold cycles, strobe low
//   DONE  | ack (and err) for one cycle; a new req may be accepted here
//
// Ports:
//   sys_clk    clock, rising edge
//   reset      synchronous active-high reset
//   req        request, sampled while busy is low
//   sel        binary select, latched at acceptance
//   gl         active-low gate, latched at acceptance (1 = null cycle)
//   setup_cyc  setup cycles
//   pulse_cyc  strobe length (0 behaves as 1)
//   hold_cyc   hold cycles
//   busy       high in SETUP/PULSE/HOLD
//   z          registered one-hot strobe
//   ack        one-cycle completion pulse
//   err        with ack: latched select was out of range (gate open)
// OUTS must lie in 1..2**SEL_W and CNT_W must not exceed CNT_W_MAX.
module dec_sel_seq
  import jag_dec_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int OUTS  = 8,
  parameter int CNT_W = 4
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             req,
  input  logic [SEL_W-1:0] sel,
  input  logic             gl,
  input  logic [CNT_W-1:0] setup_cyc,
  input  logic [CNT_W-1:0] pulse_cyc,
  input  logic [CNT_W-1:0] hold_cyc,
  output logic             busy,
  output logic [OUTS-1:0]  z,
  output logic             ack,
  output logic             err
);

  localparam logic [SEL_W:0] OUTS_EXT = (SEL_W+1)'(OUTS);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             gl_q, gl_d;
  logic             oor_q, oor_d;
  logic [CNT_W-1:0] p_q, p_d;
  logic [CNT_W-1:0] h_q, h_d;
  logic [OUTS-1:0]  z_q, z_d;

  logic             accept;
  logic             cnt_last;
  logic [CNT_W-1:0] pulse_clamped;
  logic [OUTS-1:0]  dec_z;

  assign accept        = req && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign cnt_last      = (cnt_q == CNT_W'(1));
  assign pulse_clamped = CNT_W'(clamp_min1(CNT_W_MAX'(pulse_cyc)));

  // Operand latches. Only an accepting edge updates them, so input changes
  // during an operation are invisible.
  always_comb begin
    sel_d = sel_q;
    gl_d  = gl_q;
    oor_d = oor_q;
    p_d   = p_q;
    h_d   = h_q;
    if (accept) begin
      sel_d = sel;
      gl_d  = gl;
      oor_d = ({1'b0, sel} >= OUTS_EXT);
      p_d   = pulse_clamped;
      h_d   = hold_cyc;
    end
  end

  // The decoder looks at the next-state latch values so that a zero-setup
  // operation can raise z on the very edge that accepts it.
  dec_onehot #(
    .SEL_W (SEL_W),
    .OUTS  (OUTS)
  ) u_dec (
    .sel_i (sel_d),
    .en_i  (!gl_d),
    .z_o   (dec_z)
  );

  // One shared down-counter: loaded with the phase length on entry, the
  // phase ends on the cycle it reads 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept) begin
      if (setup_cyc != '0) begin
        state_d = ST_SETUP;
        cnt_d   = setup_cyc;
      end else begin
        state_d = ST_PULSE;
        cnt_d   = pulse_clamped;
      end
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_SETUP: begin
          if (cnt_last) begin
            state_d = ST_PULSE;
            cnt_d   = p_q;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_PULSE: begin
          if (cnt_last) begin
            if (h_q != '0) begin
              state_d = ST_HOLD;
              cnt_d   = h_q;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (cnt_last) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign z_d = (state_d == ST_PULSE) ? dec_z : '0;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      gl_q    <= 1'b0;
      oor_q   <= 1'b0;
      p_q     <= '0;
      h_q     <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      gl_q    <= gl_d;
      oor_q   <= oor_d;
      p_q     <= p_d;
      h_q     <= h_d;
      z_q     <= z_d;
    end
  end

  assign z    = z_q;
  assign busy = (state_q == ST_SETUP) || (state_q == ST_PULSE) || (state_q == ST_HOLD);
  assign ack  = (state_q == ST_DONE);
  assign err  = (state_q == ST_DONE) && oor_q && !gl_q;

endmodule

// File: tb/tb_dec_sel_seq.sv
module tb_dec_sel_seq;

  logic       sys_clk = 1'b0;
  logic       reset   = 1'b1;
  logic       req     = 1'b0;
  logic [2:0] sel     = 3'd0;
  logic       gl      = 1'b0;
  logic [3:0] setup_cyc = 4'd0;
  logic [3:0] pulse_cyc = 4'd0;
  logic [3:0] hold_cyc  = 4'd0;

  logic       busy8, ack8, err8;
  logic [7:0] z8;
  logic       busy6, ack6, err6;
  logic [5:0] z6;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 sys_clk = ~sys_clk;

  dec_sel_seq #(.SEL_W(3), .OUTS(8), .CNT_W(4)) u_dut8 (
    .sys_clk(sys_clk), .reset(reset), .req(req), .sel(sel), .gl(gl),
    .setup_cyc(setup_cyc), .pulse_cyc(pulse_cyc), .hold_cyc(hold_cyc),
    .busy(busy8), .z(z8), .ack(ack8), .err(err8)
  );

  dec_sel_seq #(.SEL_W(3), .OUTS(6), .CNT_W(4)) u_dut6 (
    .sys_clk(sys_clk), .reset(reset), .req(req), .sel(sel), .gl(gl),
    .setup_cyc(setup_cyc), .pulse_cyc(pulse_cyc), .hold_cyc(hold_cyc),
    .busy(busy6), .z(z6), .ack(ack6), .err(err6)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: one operation described by its acceptance cycle and
  // latched parameters; outputs after edge c follow from rel = c - t0.
  // busy rel 0..S+P+H-1, strobe rel S..S+P-1, ack at rel S+P+H.
  bit  m_active = 1'b0;
  int  m_t0 = 0, m_sel = 0, m_s = 0, m_p = 1, m_h = 0;
  bit  m_gl = 1'b0;
  bit         exp_busy = 1'b0, exp_ack = 1'b0, exp_err8 = 1'b0, exp_err6 = 1'b0;
  logic [7:0] exp_z8 = '0;
  logic [5:0] exp_z6 = '0;

  function automatic bit busy_at(int c);
    int rel;
    rel = c - m_t0;
    return m_active && (rel >= 0) && (rel <= m_s + m_p + m_h - 1);
  endfunction

  initial begin
    int rel;
    bit in_pulse;
    forever begin
      @(posedge sys_clk);
      cyc = cyc + 1;
      if (reset) begin
        m_active = 1'b0;
      end else if (req && !busy_at(cyc - 1)) begin
        m_active = 1'b1;
        m_t0  = cyc;
        m_sel = int'(sel);
        m_gl  = gl;
        m_s   = int'(setup_cyc);
        m_p   = (pulse_cyc == 4'd0) ? 1 : int'(pulse_cyc);
        m_h   = int'(hold_cyc);
      end
      rel      = cyc - m_t0;
      exp_busy = busy_at(cyc);
      in_pulse = m_active && (rel >= m_s) && (rel <= m_s + m_p - 1);
      exp_ack  = m_active && (rel == m_s + m_p + m_h);
      exp_z8   = '0;
      exp_z6   = '0;
      if (in_pulse && !m_gl && m_sel < 8) exp_z8[m_sel] = 1'b1;
      if (in_pulse && !m_gl && m_sel < 6) exp_z6[m_sel] = 1'b1;
      exp_err8 = exp_ack && !m_gl && (m_sel >= 8);
      exp_err6 = exp_ack && !m_gl && (m_sel >= 6);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (cyc > 0) begin
        chk("model_busy8", 32'(busy8), 32'(exp_busy));
        chk("model_ack8",  32'(ack8),  32'(exp_ack));
        chk("model_err8",  32'(err8),  32'(exp_err8));
        chk("model_z8",    32'(z8),    32'(exp_z8));
        chk("model_busy6", 32'(busy6), 32'(exp_busy));
        chk("model_ack6",  32'(ack6),  32'(exp_ack));
        chk("model_err6",  32'(err6),  32'(exp_err6));
        chk("model_z6",    32'(z6),    32'(exp_z6));
        chk("onehot0_z8",  32'($onehot0(z8)), 32'd1);
        chk("onehot0_z6",  32'($onehot0(z6)), 32'd1);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic setop(input logic [2:0] s_sel, input logic s_gl,
                       input logic [3:0] s, input logic [3:0] p, input logic [3:0] h);
    sel = s_sel; gl = s_gl; setup_cyc = s; pulse_cyc = p; hold_cyc = h;
  endtask

  initial begin
    tick(3);
    reset = 1'b0;
    chk("reset_busy", 32'(busy8), 32'd0);
    chk("reset_z",    32'(z8),    32'd0);
    chk("reset_ack",  32'(ack8),  32'd0);
    tick(2);

    // S=2 P=3 H=1 sel=5
    setop(3'd5, 1'b0, 4'd2, 4'd3, 4'd1); req = 1'b1;
    tick();                                     // after E0
    req = 1'b0;
    chk("t1_e0_busy", 32'(busy8), 32'd1);
    chk("t1_e0_z",    32'(z8),    32'd0);
    tick(2);                                    // after E2
    chk("t1_e2_z", 32'(z8), 32'h20);
    tick(2);                                    // after E4
    chk("t1_e4_z", 32'(z8), 32'h20);
    tick();                                     // after E5
    chk("t1_e5_z",    32'(z8),    32'd0);
    chk("t1_e5_busy", 32'(busy8), 32'd1);
    tick();                                     // after E6
    chk("t1_e6_ack",  32'(ack8),  32'd1);
    chk("t1_e6_busy", 32'(busy8), 32'd0);
    tick();
    chk("t1_e7_ack",  32'(ack8),  32'd0);
    tick(2);

    // minimum op, back-to-back through the ack cycle
    setop(3'd0, 1'b0, 4'd0, 4'd0, 4'd0); req = 1'b1;
    tick();                                     // after E0
    chk("t2_e0_z", 32'(z8), 32'h01);
    tick();                                     // after E1
    chk("t2_e1_ack", 32'(ack8), 32'd1);
    chk("t2_e1_z",   32'(z8),   32'd0);
    sel = 3'd1;
    tick();                                     // after E2: second op
    req = 1'b0;
    chk("t2_e2_z",    32'(z8),    32'h02);
    chk("t2_e2_busy", 32'(busy8), 32'd1);
    tick();
    chk("t2_e3_ack", 32'(ack8), 32'd1);
    tick(2);

    // null cycle
    setop(3'd3, 1'b1, 4'd1, 4'd2, 4'd0); req = 1'b1;
    tick();
    req = 1'b0;
    tick(2);                                    // after E2
    chk("t3_e2_z", 32'(z8), 32'd0);
    tick();                                     // after E3
    chk("t3_e3_ack", 32'(ack8), 32'd1);
    chk("t3_e3_err", 32'(err8), 32'd0);
    tick(2);

    // out of range on the OUTS=6 instance, then last in-range select
    setop(3'd7, 1'b0, 4'd0, 4'd1, 4'd0); req = 1'b1;
    tick();
    req = 1'b0;
    chk("t4_oor_z6", 32'(z6), 32'd0);
    chk("t4_oor_z8", 32'(z8), 32'h80);
    tick();
    chk("t4_oor_ack6", 32'(ack6), 32'd1);
    chk("t4_oor_err6", 32'(err6), 32'd1);
    chk("t4_oor_err8", 32'(err8), 32'd0);
    tick();
    chk("t4_err_idle", 32'(err6), 32'd0);
    setop(3'd5, 1'b0, 4'd0, 4'd1, 4'd0); req = 1'b1;
    tick();
    req = 1'b0;
    chk("t4_in_z6", 32'(z6), 32'h20);
    tick();
    chk("t4_in_err6", 32'(err6), 32'd0);
    tick(2);

    // reset during PULSE
    setop(3'd2, 1'b0, 4'd0, 4'd4, 4'd0); req = 1'b1;
    tick();
    req = 1'b0;
    chk("t5_e0_z", 32'(z8), 32'h04);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_rst_z",    32'(z8),    32'd0);
    chk("t5_rst_busy", 32'(busy8), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t5_no_ack", 32'(ack8), 32'd0);
    end

    // inputs toggled while busy are ignored
    setop(3'd4, 1'b0, 4'd1, 4'd2, 4'd1); req = 1'b1;
    tick();                                     // after E0
    setop(3'd1, 1'b1, 4'd7, 4'd7, 4'd7);
    tick();                                     // after E1
    chk("t6_e1_z", 32'(z8), 32'h10);
    setop(3'd6, 1'b0, 4'd0, 4'd0, 4'd0);
    tick();                                     // after E2
    chk("t6_e2_z", 32'(z8), 32'h10);
    tick();                                     // after E3
    req = 1'b0;
    chk("t6_e3_z",    32'(z8),    32'd0);
    chk("t6_e3_busy", 32'(busy8), 32'd1);
    tick();                                     // after E4
    chk("t6_e4_ack", 32'(ack8), 32'd1);
    tick(3);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      req = ($urandom_range(0, 2) != 0);
      sel = 3'($urandom_range(0, 7));
      gl  = ($urandom_range(0, 3) == 0);
      setup_cyc = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      pulse_cyc = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      hold_cyc  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;
    req   = 1'b0;
    tick(60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
